// File: rtl/bfly_stage_if.sv
// Beat-stream and control bundle between an upstream sample source and the
// butterfly stage controller.
interface bfly_stage_if #(
  parameter int AW = 4
);
  logic          valid_in;
  logic          sop_in;
  logic          clr_err;
  logic          sr_write;
  logic          sr_read;
  logic          bfly_en;
  logic [AW-1:0] tw_addr;
  logic          out_sel;
  logic          valid_out;
  logic          sop_out;
  logic          eop_out;
  logic          busy;
  logic          err_overrun;
  logic          err_sync;

  modport master (
    output valid_in, sop_in, clr_err,
    input  sr_write, sr_read, bfly_en, tw_addr, out_sel,
    input  valid_out, sop_out, eop_out, busy, err_overrun, err_sync
  );

  modport slave (
    input  valid_in, sop_in, clr_err,
    output sr_write, sr_read, bfly_en, tw_addr, out_sel,
    output valid_out, sop_out, eop_out, busy, err_overrun, err_sync
  );
endinterface

// File: rtl/bfly_stage_ctrl.sv
// Sequencer for one radix-2 butterfly stage: fills a half-frame delay line,
// computes against the second half, then drains the stored differences.
module bfly_stage_ctrl #(
  parameter int NUM  = 16,
  parameter int DATA = 512,
  parameter int HALF = DATA / NUM / 2,
  parameter int AW   = (HALF > 1) ? $clog2(HALF) : 1
) (
  input  logic      clk,
  input  logic      rstn,
  bfly_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, COMPUTE, DRAIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(HALF - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] tw_q, tw_d;
  logic          wr_d, rd_d, en_d, sel_d;
  logic          ovr_set, sync_set;
  logic          last;

  logic sr_write_q, sr_read_q, bfly_en_q, out_sel_q;
  logic valid_out_q, sop_out_q, eop_out_q, busy_q;
  logic ovr_q, sync_q;

  assign last = (cnt_q == LAST);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tw_d     = tw_q;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    en_d     = 1'b0;
    sel_d    = 1'b0;
    ovr_set  = 1'b0;
    sync_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.valid_in && bus.sop_in) begin
          state_d = FILL;
          cnt_d   = AW'(1);
          wr_d    = 1'b1;
        end
      end

      FILL, COMPUTE: begin
        if (bus.valid_in) begin
          if (bus.sop_in) begin
            // A fresh start-of-frame abandons the current frame; its beat
            // becomes beat 0 of the new one.
            sync_set = 1'b1;
            state_d  = FILL;
            cnt_d    = AW'(1);
            wr_d     = 1'b1;
          end else begin
            cnt_d = last ? '0 : cnt_q + AW'(1);
            if (state_q == FILL) begin
              wr_d = 1'b1;
              if (last) state_d = COMPUTE;
            end else begin
              rd_d = 1'b1;
              en_d = 1'b1;
              tw_d = cnt_q;
              if (last) state_d = DRAIN;
            end
          end
        end
      end

      DRAIN: begin
        // Drain runs unconditionally; any beat offered now is lost.
        rd_d    = 1'b1;
        sel_d   = 1'b1;
        cnt_d   = last ? '0 : cnt_q + AW'(1);
        ovr_set = bus.valid_in;
        if (last) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tw_q        <= '0;
      sr_write_q  <= 1'b0;
      sr_read_q   <= 1'b0;
      bfly_en_q   <= 1'b0;
      out_sel_q   <= 1'b0;
      valid_out_q <= 1'b0;
      sop_out_q   <= 1'b0;
      eop_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tw_q       <= tw_d;
      sr_write_q <= wr_d;
      sr_read_q  <= rd_d;
      bfly_en_q  <= en_d;
      out_sel_q  <= sel_d;
      busy_q     <= (state_d != IDLE);

      // Output beat follows its compute or drain strobe by one cycle.
      valid_out_q <= bfly_en_q | out_sel_q;
      sop_out_q   <= bfly_en_q && (tw_q == '0);
      // Only the final drain strobe coincides with the FSM back in IDLE.
      eop_out_q   <= out_sel_q && (state_q == IDLE);

      if (ovr_set)          ovr_q <= 1'b1;
      else if (bus.clr_err) ovr_q <= 1'b0;

      if (sync_set)         sync_q <= 1'b1;
      else if (bus.clr_err) sync_q <= 1'b0;
    end
  end

  assign bus.sr_write    = sr_write_q;
  assign bus.sr_read     = sr_read_q;
  assign bus.bfly_en     = bfly_en_q;
  assign bus.tw_addr     = tw_q;
  assign bus.out_sel     = out_sel_q;
  assign bus.valid_out   = valid_out_q;
  assign bus.sop_out     = sop_out_q;
  assign bus.eop_out     = eop_out_q;
  assign bus.busy        = busy_q;
  assign bus.err_overrun = ovr_q;
  assign bus.err_sync    = sync_q;

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// Scoreboard bench for bfly_stage_ctrl: a frame-level timing model predicts
// every strobe and output beat; a monitor compares them cycle by cycle.
module tb_bfly_stage_ctrl;
  localparam int HALF = 16;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  bfly_stage_if #(.AW(AW)) bus ();

  bfly_stage_ctrl #(.NUM(16), .DATA(512)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int stamp; int tw; } comp_t;
  typedef struct { int stamp; bit sel; bit sop; bit eop; } out_t;

  // Expected events, keyed by the clock-edge count after which they are visible.
  int    wq[$];
  comp_t cq[$];
  int    dq[$];
  out_t  oq[$];

  // Frame-level reference state.
  int f_stored   = 0;
  int c_computed = 0;
  int drain_last = -1;
  bit ovr_m      = 1'b0;
  bit syn_m      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    wq.delete(); cq.delete(); dq.delete(); oq.delete();
    f_stored = 0; c_computed = 0; drain_last = -1;
    ovr_m = 1'b0; syn_m = 1'b0;
  endtask

  // Beat offered for acceptance at clock edge n.
  task automatic model(input bit v, input bit s, input bit cl, input int n);
    bit ev_ovr = 1'b0;
    bit ev_syn = 1'b0;
    if (v) begin
      if (n <= drain_last) begin
        ev_ovr = 1'b1;
      end else if (s) begin
        ev_syn     = (f_stored > 0);
        f_stored   = 1;
        c_computed = 0;
        wq.push_back(n);
      end else if (f_stored == 0) begin
        // stray beat outside a frame: ignored
      end else if (f_stored < HALF) begin
        wq.push_back(n);
        f_stored++;
      end else begin
        cq.push_back('{stamp: n, tw: c_computed});
        oq.push_back('{stamp: n + 1, sel: 1'b0, sop: (c_computed == 0), eop: 1'b0});
        c_computed++;
        if (c_computed == HALF) begin
          for (int i = 0; i < HALF; i++) begin
            dq.push_back(n + 1 + i);
            oq.push_back('{stamp: n + 2 + i, sel: 1'b1, sop: 1'b0, eop: (i == HALF - 1)});
          end
          drain_last = n + HALF;
          f_stored   = 0;
          c_computed = 0;
        end
      end
    end
    if (ev_ovr)  ovr_m = 1'b1;
    else if (cl) ovr_m = 1'b0;
    if (ev_syn)  syn_m = 1'b1;
    else if (cl) syn_m = 1'b0;
  endtask

  task automatic apply(input bit v, input bit s, input bit cl);
    bus.valid_in = v;
    bus.sop_in   = s;
    bus.clr_err  = cl;
    model(v, s, cl, cyc + 1);
  endtask

  task automatic drive(input bit v, input bit s, input bit cl);
    @(negedge clk);
    apply(v, s, cl);
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, 1'b0);
  endtask

  // gap: 0 contiguous, 1 every other cycle, 2 random 0..2 idle cycles
  task automatic send_frame(input int gap);
    for (int i = 0; i < 2 * HALF; i++) begin
      drive(1'b1, (i == 0), 1'b0);
      if (gap == 1) idle(1);
      else if (gap == 2) idle($urandom_range(0, 2));
    end
  endtask

  task automatic check_state(input string tag);
    idle(1);
    check({tag, "_err_overrun"}, bus.err_overrun, ovr_m);
    check({tag, "_err_sync"}, bus.err_sync, syn_m);
    check({tag, "_busy"}, bus.busy, (f_stored > 0) || (cyc < drain_last));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sr_write"},    bus.sr_write,    0);
    check({tag, "_sr_read"},     bus.sr_read,     0);
    check({tag, "_bfly_en"},     bus.bfly_en,     0);
    check({tag, "_tw_addr"},     bus.tw_addr,     0);
    check({tag, "_out_sel"},     bus.out_sel,     0);
    check({tag, "_valid_out"},   bus.valid_out,   0);
    check({tag, "_sop_out"},     bus.sop_out,     0);
    check({tag, "_eop_out"},     bus.eop_out,     0);
    check({tag, "_busy"},        bus.busy,        0);
    check({tag, "_err_overrun"}, bus.err_overrun, 0);
    check({tag, "_err_sync"},    bus.err_sync,    0);
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_zero("rst");
    model_reset();
    repeat (hold) @(negedge clk);
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
    bus.clr_err  = 1'b0;
    rstn = 1'b1;
  endtask

  // Monitor: one sample per cycle, mid-way between rising edges.
  initial begin : monitor
    int    last_tw  = 0;
    bit    prev_sel = 1'b0;
    bit    ew, ec, ed, eo;
    comp_t cx;
    out_t  ox;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_tw  = 0;
        prev_sel = 1'b0;
      end else begin
        while (wq.size() > 0 && wq[0] < cyc) begin
          check("sr_write_stale", wq[0], cyc); void'(wq.pop_front());
        end
        while (cq.size() > 0 && cq[0].stamp < cyc) begin
          check("bfly_en_stale", cq[0].stamp, cyc); void'(cq.pop_front());
        end
        while (dq.size() > 0 && dq[0] < cyc) begin
          check("drain_stale", dq[0], cyc); void'(dq.pop_front());
        end
        while (oq.size() > 0 && oq[0].stamp < cyc) begin
          check("valid_out_stale", oq[0].stamp, cyc); void'(oq.pop_front());
        end

        ew = (wq.size() > 0) && (wq[0] == cyc);
        ec = (cq.size() > 0) && (cq[0].stamp == cyc);
        ed = (dq.size() > 0) && (dq[0] == cyc);
        eo = (oq.size() > 0) && (oq[0].stamp == cyc);

        check("sr_write", bus.sr_write, ew);
        check("bfly_en",  bus.bfly_en,  ec);
        check("sr_read",  bus.sr_read,  ec || ed);
        check("out_sel",  bus.out_sel,  ed);
        if (ew) void'(wq.pop_front());
        if (ed) void'(dq.pop_front());

        if (ec) begin
          cx = cq.pop_front();
          check("tw_addr", bus.tw_addr, cx.tw);
          last_tw = cx.tw;
        end else begin
          check("tw_addr_hold", bus.tw_addr, last_tw);
        end

        check("valid_out", bus.valid_out, eo);
        if (eo) begin
          ox = oq.pop_front();
          check("out_path", prev_sel, ox.sel);
          check("sop_out",  bus.sop_out, ox.sop);
          check("eop_out",  bus.eop_out, ox.eop);
        end else begin
          check("sop_out_quiet", bus.sop_out, 0);
          check("eop_out_quiet", bus.eop_out, 0);
        end
        prev_sel = bus.out_sel;
      end
    end
  end

  initial begin : stimulus
    rstn         = 1'b1;
    bus.valid_in = 1'b0;
    bus.sop_in   = 1'b0;
    bus.clr_err  = 1'b0;
    #1 rstn = 1'b0;
    #1 check_zero("por");
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Contiguous frame, first beat right after reset release.
    apply(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 2 * HALF; i++) drive(1'b1, 1'b0, 1'b0);
    idle(HALF + 4);
    check_state("contig");

    // Valid every other cycle, then random gaps.
    send_frame(1);
    idle(HALF + 4);
    check_state("gapped");
    repeat (3) send_frame(2);
    idle(HALF + 4);
    check_state("rgap");

    // Start-of-frame at compute beat 5 abandons the frame.
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < HALF + 5; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check_state("midsop");
    for (int i = 1; i < 2 * HALF; i++) drive(1'b1, 1'b0, 1'b0);
    idle(HALF + 4);
    check_state("midsop_done");
    drive(1'b0, 1'b0, 1'b1);
    check_state("midsop_clr");

    // Beat offered during drain cycle 3.
    send_frame(0);
    idle(2);
    drive(1'b1, 1'b0, 1'b0);
    check_state("overrun");
    idle(HALF);
    check_state("overrun_done");
    drive(1'b0, 1'b0, 1'b1);
    check_state("overrun_clr");

    // Clear and overrun on the same edge: the error wins.
    send_frame(0);
    idle(1);
    drive(1'b1, 1'b0, 1'b1);
    idle(HALF);
    check_state("clr_race");
    drive(1'b0, 1'b0, 1'b1);
    check_state("clr_race_clr");

    // Start-of-frame on the final drain cycle is dropped.
    send_frame(0);
    idle(HALF - 1);
    drive(1'b1, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 1'b0, 1'b0);
    check_state("last_drain_sop");
    drive(1'b0, 1'b0, 1'b1);

    // Back-to-back frames: next start on the cycle after drain ends.
    send_frame(0);
    idle(HALF);
    send_frame(0);
    idle(HALF + 4);
    check_state("b2b");

    // Reset during fill beat 8, then stray beats without start.
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 1'b0);
    pulse_reset(2);
    repeat (6) drive(1'b1, 1'b0, 1'b0);
    check_state("post_reset");

    // Random traffic with occasional restarts and clears.
    repeat (600) drive(($urandom % 4) != 0, ($urandom % 24) == 0, ($urandom % 64) == 0);
    idle(2 * HALF + 4);
    check_state("random");

    check("wq_drained", wq.size(), 0);
    check("cq_drained", cq.size(), 0);
    check("dq_drained", dq.size(), 0);
    check("oq_drained", oq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
